// File: rtl/hack_cpu_ctrl_pkg.sv
// Shared definitions for the Hack control stage: widths, reset PC,
// FSM state encodings and instruction-word field positions.
package hack_cpu_ctrl_pkg;

  localparam int CPU_DATA_W   = 16;
  localparam int CPU_ADDR_W   = 15;
  localparam int CPU_RESET_PC = 0;

  // Instruction field bit positions
  localparam int IR_C      = 15;  // 1 = C-instruction, 0 = A-instruction
  localparam int IR_A      = 12;  // ALU y source: 1 = in_m, 0 = A
  localparam int IR_ALU_HI = 11;  // zx
  localparam int IR_ALU_LO = 6;   // no
  localparam int IR_DEST_A = 5;
  localparam int IR_DEST_D = 4;
  localparam int IR_DEST_M = 3;
  localparam int IR_JMP_LT = 2;
  localparam int IR_JMP_EQ = 1;
  localparam int IR_JMP_GT = 0;

  typedef enum logic {
    S_FETCH = 1'b0,
    S_EXEC  = 1'b1
  } cpu_state_e;

endpackage

// File: rtl/hack_cpu_ctrl_alu16.sv
// Hack ALU16: purely combinational, six control bits zx,nx,zy,ny,f,no
// plus zero/negative flags of the result.
module hack_cpu_ctrl_alu16 (
  input  logic [15:0] x_i,
  input  logic [15:0] y_i,
  input  logic        zx_i,
  input  logic        nx_i,
  input  logic        zy_i,
  input  logic        ny_i,
  input  logic        f_i,
  input  logic        no_i,
  output logic [15:0] out_o,
  output logic        zr_o,
  output logic        ng_o
);

  logic [15:0] x_z, x_n, y_z, y_n, f_res;

  // Operand preconditioning, function select and output negation
  always_comb begin
    x_z   = zx_i ? 16'h0000 : x_i;
    x_n   = nx_i ? ~x_z : x_z;
    y_z   = zy_i ? 16'h0000 : y_i;
    y_n   = ny_i ? ~y_z : y_z;
    f_res = f_i ? (x_n + y_n) : (x_n & y_n);
    out_o = no_i ? ~f_res : f_res;
    zr_o  = (out_o == 16'h0000);
    ng_o  = out_o[15];
  end

endmodule

// File: rtl/hack_cpu_ctrl.sv
// Hack control/register stage: FETCH/EXEC core holding A, D, PC and IR,
// driving the ALU16 and handling instruction-fetch and store handshakes.
// Optional build macro CPU_RETIRE_CNT_EN adds a 32-bit retired-instruction
// counter and its output port.
//
//  state   | meaning
//  S_FETCH | fetch_req high, waiting for instr_valid to latch IR
//  S_EXEC  | decode/execute IR; stores hold here until mem_ack
module hack_cpu_ctrl
  import hack_cpu_ctrl_pkg::*;
#(
  parameter int DATA_W   = CPU_DATA_W,
  parameter int ADDR_W   = CPU_ADDR_W,
  parameter int RESET_PC = CPU_RESET_PC
) (
  input  logic              clk,
  input  logic              reset,
  output logic              fetch_req,
  output logic [ADDR_W-1:0] pc,
  input  logic [DATA_W-1:0] instr,
  input  logic              instr_valid,
  input  logic [DATA_W-1:0] in_m,
  output logic [ADDR_W-1:0] addr_m,
  output logic [DATA_W-1:0] out_m,
  output logic              write_m,
  input  logic              mem_ack
`ifdef CPU_RETIRE_CNT_EN
  ,
  output logic [31:0]       retired
`endif
);

  cpu_state_e        state_q;
  logic [DATA_W-1:0] ir_q, a_q, d_q;
  logic [ADDR_W-1:0] pc_q;
  logic              fetch_req_q, write_m_q;

  logic [DATA_W-1:0] alu_y, alu_out;
  logic              alu_zr, alu_ng;
  logic [5:0]        alu_ctrl;
  logic              take;
  logic [ADDR_W-1:0] pc_inc, pc_d;
  logic              commit;

  // Decode, jump decision and next-PC selection (jump target is pre-commit A)
  always_comb begin
    alu_y    = ir_q[IR_A] ? in_m : a_q;
    alu_ctrl = ir_q[IR_ALU_HI:IR_ALU_LO];
    take     = (ir_q[IR_JMP_LT] & alu_ng) |
               (ir_q[IR_JMP_EQ] & alu_zr) |
               (ir_q[IR_JMP_GT] & ~alu_ng & ~alu_zr);
    pc_inc   = pc_q + 1'b1;
    pc_d     = take ? a_q[ADDR_W-1:0] : pc_inc;
    commit   = (state_q == S_EXEC) &&
               (!ir_q[IR_C] || !ir_q[IR_DEST_M] || mem_ack);
  end

  hack_cpu_ctrl_alu16 u_alu (
    .x_i   (d_q),
    .y_i   (alu_y),
    .zx_i  (alu_ctrl[5]),
    .nx_i  (alu_ctrl[4]),
    .zy_i  (alu_ctrl[3]),
    .ny_i  (alu_ctrl[2]),
    .f_i   (alu_ctrl[1]),
    .no_i  (alu_ctrl[0]),
    .out_o (alu_out),
    .zr_o  (alu_zr),
    .ng_o  (alu_ng)
  );

  // FETCH/EXEC sequencing with registered fetch_req/write_m
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_FETCH;
      ir_q        <= '0;
      a_q         <= '0;
      d_q         <= '0;
      pc_q        <= ADDR_W'(RESET_PC);
      fetch_req_q <= 1'b1;
      write_m_q   <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (instr_valid) begin
            ir_q        <= instr;
            state_q     <= S_EXEC;
            fetch_req_q <= 1'b0;
            write_m_q   <= instr[IR_C] & instr[IR_DEST_M];
          end
        end
        S_EXEC: begin
          if (!ir_q[IR_C]) begin
            a_q         <= {1'b0, ir_q[DATA_W-2:0]};
            pc_q        <= pc_inc;
            state_q     <= S_FETCH;
            fetch_req_q <= 1'b1;
          end else if (commit) begin
            if (ir_q[IR_DEST_A]) a_q <= alu_out;
            if (ir_q[IR_DEST_D]) d_q <= alu_out;
            pc_q        <= pc_d;
            write_m_q   <= 1'b0;
            state_q     <= S_FETCH;
            fetch_req_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= S_FETCH;
          fetch_req_q <= 1'b1;
          write_m_q   <= 1'b0;
        end
      endcase
    end
  end

`ifdef CPU_RETIRE_CNT_EN
  logic [31:0] retired_q;

  // Count every committed instruction, wrapping naturally at 2^32
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       retired_q <= '0;
    else if (commit) retired_q <= retired_q + 32'd1;
  end

  assign retired = retired_q;
`endif

  assign fetch_req = fetch_req_q;
  assign pc        = pc_q;
  assign addr_m    = a_q[ADDR_W-1:0];
  assign out_m     = alu_out;
  assign write_m   = write_m_q;

endmodule

// File: tb/tb_hack_cpu_ctrl.sv
// Scoreboard bench for hack_cpu_ctrl: the driver pushes hand-computed
// expectations per instruction; a monitor pops them on each commit (rising
// fetch_req) and on each store acknowledge.
module tb_hack_cpu_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_req;
  logic [14:0] pc;
  logic [15:0] instr;
  logic        instr_valid;
  logic [15:0] in_m;
  logic [14:0] addr_m;
  logic [15:0] out_m;
  logic        write_m;
  logic        mem_ack;
`ifdef CPU_RETIRE_CNT_EN
  logic [31:0] retired;
`endif

  always #5 clk = ~clk;

  hack_cpu_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .fetch_req   (fetch_req),
    .pc          (pc),
    .instr       (instr),
    .instr_valid (instr_valid),
    .in_m        (in_m),
    .addr_m      (addr_m),
    .out_m       (out_m),
    .write_m     (write_m),
    .mem_ack     (mem_ack)
`ifdef CPU_RETIRE_CNT_EN
    ,
    .retired     (retired)
`endif
  );

  typedef struct {
    logic [14:0] pc;
    logic [15:0] a;
    logic [15:0] d;
    int          wcyc;
  } exp_t;

  typedef struct {
    logic [14:0] addr;
    logic [15:0] data;
    logic [14:0] pc_hold;
  } st_t;

  typedef struct {
    logic [15:0] instr;
    logic [15:0] inm;
    int          ack;     // 0 = no store, else cycle of mem_ack within EXEC
    logic [15:0] st_data;
    logic [14:0] pc;
    logic [15:0] a;
    logic [15:0] d;
  } vec_t;

  exp_t eq[$];
  st_t  sq[$];
  vec_t vecs[$];

  int total = 0;
  int bad   = 0;

  logic [14:0] prev_pc = 15'd0;
  logic [15:0] prev_a  = 16'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [15:0] i, input logic [15:0] m, input int ack,
                     input logic [15:0] sd, input logic [14:0] p,
                     input logic [15:0] a, input logic [15:0] d);
    vec_t v;
    v.instr = i; v.inm = m; v.ack = ack; v.st_data = sd;
    v.pc = p; v.a = a; v.d = d;
    vecs.push_back(v);
  endtask

  task automatic wait_fetch(output bit ok);
    int n = 0;
    while (!fetch_req && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    ok = fetch_req;
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL fetch_timeout: fetch_req=%0b after %0d cycles required 1", fetch_req, n);
    end
  endtask

  task automatic run_vec(input vec_t v);
    bit   ok;
    exp_t e;
    st_t  s;
    wait_fetch(ok);
    if (!ok) return;
    e.pc = v.pc; e.a = v.a; e.d = v.d; e.wcyc = v.ack;
    eq.push_back(e);
    if (v.ack > 0) begin
      s.addr = prev_a[14:0]; s.data = v.st_data; s.pc_hold = prev_pc;
      sq.push_back(s);
    end
    instr = v.instr; in_m = v.inm; instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    if (v.ack > 0) begin
      repeat (v.ack - 1) begin @(posedge clk); #1; end
      mem_ack = 1'b1;
      @(posedge clk); #1;
      mem_ack = 1'b0;
    end else begin
      @(posedge clk); #1;
    end
    prev_pc = v.pc;
    prev_a  = v.a;
  endtask

  // Monitor: compare on store ack and on every commit (fetch_req rising)
  initial begin
    bit   fprev = 1'b1;
    int   wcnt = 0;
    exp_t e;
    st_t  s;
    forever begin
      @(negedge clk);
      if (reset) begin
        fprev = fetch_req;
        wcnt  = 0;
      end else begin
        if (write_m) begin
          wcnt++;
          if (sq.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_store: write_m=1 addr_m=0x%0h required no store", addr_m);
          end else begin
            chk("stall_pc", 32'(pc), 32'(sq[0].pc_hold));
            if (mem_ack) begin
              s = sq.pop_front();
              chk("store_addr", 32'(addr_m), 32'(s.addr));
              chk("store_data", 32'(out_m), 32'(s.data));
            end
          end
        end
        if (fetch_req && !fprev) begin
          if (eq.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_commit: pc=0x%0h required no commit", pc);
          end else begin
            e = eq.pop_front();
            chk("commit_pc", 32'(pc), 32'(e.pc));
            chk("commit_a", 32'(dut.a_q), 32'(e.a));
            chk("commit_d", 32'(dut.d_q), 32'(e.d));
            chk("write_cycles", 32'(wcnt), 32'(e.wcyc));
          end
          wcnt = 0;
        end
        fprev = fetch_req;
      end
    end
  end

  // Driver
  initial begin
    bit   ok;
    vec_t v;
    reset = 1'b1; instr = '0; instr_valid = 1'b0; in_m = '0; mem_ack = 1'b0;

    // instr      in_m  ack data    pc       A        D
    add(16'h0064, 16'd0, 0, 16'd0, 15'd1,  16'd100, 16'd0);   // @100
    add(16'hEC10, 16'd0, 0, 16'd0, 15'd2,  16'd100, 16'd100); // D=A
    add(16'h0003, 16'd0, 0, 16'd0, 15'd3,  16'd3,   16'd100); // @3
    add(16'hE4D0, 16'd0, 0, 16'd0, 15'd4,  16'd3,   16'd97);  // D=D-A
    add(16'hEA90, 16'd0, 0, 16'd0, 15'd5,  16'd3,   16'd0);   // D=0
    add(16'h0007, 16'd0, 0, 16'd0, 15'd6,  16'd7,   16'd0);   // @7
    add(16'hE302, 16'd0, 0, 16'd0, 15'd7,  16'd7,   16'd0);   // D;JEQ taken
    add(16'h0005, 16'd0, 0, 16'd0, 15'd8,  16'd5,   16'd0);   // @5
    add(16'hEC10, 16'd0, 0, 16'd0, 15'd9,  16'd5,   16'd5);   // D=A
    add(16'h0007, 16'd0, 0, 16'd0, 15'd10, 16'd7,   16'd5);   // @7
    add(16'hE302, 16'd0, 0, 16'd0, 15'd11, 16'd7,   16'd5);   // D;JEQ not taken
    add(16'h0014, 16'd0, 0, 16'd0, 15'd12, 16'd20,  16'd5);   // @20
    add(16'h0009, 16'd0, 0, 16'd0, 15'd13, 16'd9,   16'd5);   // @9
    add(16'hEC10, 16'd0, 0, 16'd0, 15'd14, 16'd9,   16'd9);   // D=A
    add(16'h0014, 16'd0, 0, 16'd0, 15'd15, 16'd20,  16'd9);   // @20
    add(16'hE308, 16'd0, 3, 16'd9, 15'd16, 16'd20,  16'd9);   // M=D, ack 3rd cycle
    add(16'h0032, 16'd0, 0, 16'd0, 15'd17, 16'd50,  16'd9);   // @50
    add(16'hEDE7, 16'd0, 0, 16'd0, 15'd50, 16'd51,  16'd9);   // A=A+1;JMP -> old A
    add(16'hEC27, 16'd0, 0, 16'd0, 15'd51, 16'd51,  16'd9);   // A=A;JMP
    add(16'hFDC8, 16'd41,1, 16'd42,15'd52, 16'd51,  16'd9);   // M=M+1
    add(16'h7FFF, 16'd0, 0, 16'd0, 15'd53, 16'h7FFF,16'd9);   // @32767
    add(16'hEA87, 16'd0, 0, 16'd0, 15'h7FFF,16'h7FFF,16'd9);  // 0;JMP
    add(16'h0005, 16'd0, 0, 16'd0, 15'd0,  16'd5,   16'd9);   // pc wraps
    add(16'hEE90, 16'd0, 0, 16'd0, 15'd1,  16'd5,   16'hFFFF);// D=-1
    add(16'h0009, 16'd0, 0, 16'd0, 15'd2,  16'd9,   16'hFFFF);// @9
    add(16'hE304, 16'd0, 0, 16'd0, 15'd9,  16'd9,   16'hFFFF);// D;JLT taken
    add(16'hE301, 16'd0, 0, 16'd0, 15'd10, 16'd9,   16'hFFFF);// D;JGT not taken
    add(16'hE7D8, 16'd0, 2, 16'd0, 15'd11, 16'd9,   16'd0);   // MD=D+1, ack 2nd
    add(16'h0014, 16'd0, 0, 16'd0, 15'd12, 16'd20,  16'd0);   // @20

    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_a", 32'(dut.a_q), 32'd0);
    chk("rst_d", 32'(dut.d_q), 32'd0);
    chk("rst_write_m", 32'(write_m), 32'd0);
    chk("rst_fetch_req", 32'(fetch_req), 32'd1);
`ifdef CPU_RETIRE_CNT_EN
    chk("rst_retired", retired, 32'd0);
`endif
    reset = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

`ifdef CPU_RETIRE_CNT_EN
    chk("retired_count", retired, 32'(vecs.size()));
`endif

    // Store aborted by reset mid-stall: no commit, everything back to reset
    wait_fetch(ok);
    if (ok) begin
      st_t s;
      s.addr = 15'd20; s.data = 16'd0; s.pc_hold = 15'd12;
      sq.push_back(s);
      instr = 16'hE308; instr_valid = 1'b1;
      @(posedge clk); #1;
      instr_valid = 1'b0;
      @(posedge clk); #1;
      chk("abort_write_m_pre", 32'(write_m), 32'd1);
      reset = 1'b1;
      #1;
      chk("abort_write_m", 32'(write_m), 32'd0);
      chk("abort_pc", 32'(pc), 32'd0);
      chk("abort_a", 32'(dut.a_q), 32'd0);
      chk("abort_d", 32'(dut.d_q), 32'd0);
      chk("abort_fetch_req", 32'(fetch_req), 32'd1);
`ifdef CPU_RETIRE_CNT_EN
      chk("abort_retired", retired, 32'd0);
`endif
      @(posedge clk); #1;
      reset = 1'b0;
      sq.delete();
    end

    prev_pc = 15'd0;
    prev_a  = 16'd0;
    v.instr = 16'h0003; v.inm = 16'd0; v.ack = 0; v.st_data = 16'd0;
    v.pc = 15'd1; v.a = 16'd3; v.d = 16'd0;
    run_vec(v);

    repeat (3) @(posedge clk);
    #1;
    chk("exp_queue_drained", 32'(eq.size()), 32'd0);
    chk("store_queue_drained", 32'(sq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
